fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 35 +++
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: decode/execute control, instruction memory port and queue head.
// Performance counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_queue_if;
    logic        stall;
    logic        do_branch;
    logic [31:0] pc_effective;
    logic [31:0] address;
    logic [1:0]  access_size;
    logic        rw;
    logic        i_mem_enable;
    logic [31:0] imem_data;
    logic        insn_valid;
    logic [31:0] insn_out;
    logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    modport master (
        input  stall, do_branch, pc_effective, imem_data,
        output address, access_size, rw, i_mem_enable, insn_valid, insn_out, pc_out
`ifdef FETCH_PERF_CNT_EN
        , output fetch_count, stall_count
`endif
    );

    modport slave (
        output stall, do_branch, pc_effective, imem_data,
        input  address, access_size, rw, i_mem_enable, insn_valid, insn_out, pc_out
`ifdef FETCH_PERF_CNT_EN
        , input fetch_count, stall_count
`endif
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: fixed-latency imem requests feeding a DEPTH-entry queue.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue #(
    parameter logic [31:0] BASE_ADDR = 32'h80020000,
    parameter int unsigned DEPTH     = 4,
    parameter logic [1:0]  WORD_SIZE = 2'b00
) (
    input logic         clock,
    input logic         reset,
    fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fpc_q, fpc_d;
    logic [31:0]      tag_q, tag_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] occupancy;
    logic             inflight_q, inflight_d;
    logic             squash_q, squash_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [31:0]      last_insn_q, last_insn_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      insn_mem_q [DEPTH];
    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;

    always_comb begin
        fpc_d       = fpc_q;
        tag_d       = tag_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        last_pc_d   = last_pc_q;
        last_insn_d = last_insn_q;

        head_valid = (count_q != '0);
        // Queued entries plus the outstanding response must never exceed DEPTH,
        // so a response always finds a free slot.
        occupancy  = count_q + CNT_W'(inflight_q);
        issue      = !reset && !bus.do_branch && (occupancy < CNT_W'(DEPTH));
        push       = inflight_q && !squash_q && !bus.do_branch;
        pop        = head_valid && !bus.stall && !bus.do_branch;

        inflight_d = issue;
        squash_d   = bus.do_branch;

        if (issue) begin
            fpc_d = fpc_q + 32'd4;
            tag_d = fpc_q;
        end

        // Remember what is on display so the outputs hold once the queue drains.
        if (head_valid) begin
            last_pc_d   = pc_mem_q[head_q];
            last_insn_d = insn_mem_q[head_q];
        end

        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (bus.do_branch) begin
            fpc_d   = {bus.pc_effective[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc_q       <= BASE_ADDR;
            tag_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            squash_q    <= 1'b0;
            last_pc_q   <= '0;
            last_insn_q <= '0;
        end else begin
            fpc_q       <= fpc_d;
            tag_q       <= tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            squash_q    <= squash_d;
            last_pc_q   <= last_pc_d;
            last_insn_q <= last_insn_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            pc_mem_q[tail_q]   <= tag_q;
            insn_mem_q[tail_q] <= bus.imem_data;
        end
    end

    assign bus.address      = fpc_q;
    assign bus.access_size  = WORD_SIZE;
    assign bus.rw           = 1'b1;
    assign bus.i_mem_enable = issue;
    assign bus.insn_valid   = head_valid;
    assign bus.pc_out       = head_valid ? pc_mem_q[head_q]   : last_pc_q;
    assign bus.insn_out     = head_valid ? insn_mem_q[head_q] : last_insn_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (push)                    fetch_count_q <= fetch_count_q + 32'd1;
            if (head_valid && bus.stall) stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_count_q;
    assign bus.stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random stall/branch/reset
// traffic checked against a stream-level model of requested and delivered PCs.
module tb_fetch_queue;
    localparam logic [31:0] BASE  = 32'h80020000;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fetch_queue_if bus();

    fetch_queue #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .WORD_SIZE (2'b00)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Instruction memory returns the requested address as data, one cycle later.
    always @(posedge clock)
        bus.imem_data <= bus.i_mem_enable ? bus.address : 32'hDEADBEEF;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    // Reference model: requests and deliveries each form a +4 stream restarting
    // at every redirect; the outstanding count never exceeds DEPTH.
    bit          mon_on = 1'b0;
    logic [31:0] exp_head, exp_req, last_pc;
    int          outstanding;

    always @(negedge clock) begin
        if (mon_on) begin
            if (reset) begin
                check_val("en_in_reset", 32'(bus.i_mem_enable), 32'd0);
                exp_head    = BASE;
                exp_req     = BASE;
                last_pc     = '0;
                outstanding = 0;
            end else begin
                if (bus.insn_valid) begin
                    check_val("head_pc", bus.pc_out, exp_head);
                    check_val("head_insn", bus.insn_out, exp_head);
                    check_val("valid_has_src", 32'(outstanding > 0), 32'd1);
                    last_pc = exp_head;
                end else begin
                    check_val("hold_pc", bus.pc_out, last_pc);
                    check_val("hold_insn", bus.insn_out, last_pc);
                end
                if (bus.do_branch) begin
                    check_val("en_in_branch", 32'(bus.i_mem_enable), 32'd0);
                    exp_head    = {bus.pc_effective[31:2], 2'b00};
                    exp_req     = exp_head;
                    outstanding = 0;
                end else begin
                    if (bus.i_mem_enable) begin
                        check_val("req_addr", bus.address, exp_req);
                        exp_req     = exp_req + 32'd4;
                        outstanding = outstanding + 1;
                        check_val("occupancy", 32'(outstanding > int'(DEPTH)), 32'd0);
                    end
                    if (bus.insn_valid && !bus.stall) begin
                        exp_head    = exp_head + 32'd4;
                        outstanding = outstanding - 1;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    int pushes_m = 0;
    int stalls_m = 0;
    bit pend_m   = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            pushes_m = 0;
            stalls_m = 0;
            pend_m   = 1'b0;
        end else begin
            if (pend_m && !bus.do_branch) pushes_m++;
            if (bus.insn_valid && bus.stall) stalls_m++;
            pend_m = bus.i_mem_enable;
        end
    end
`endif

    initial begin
        int reqs;
        reset            = 1'b1;
        bus.stall        = 1'b0;
        bus.do_branch    = 1'b0;
        bus.pc_effective = '0;

        // Reset state
        cyc();
        mon_on = 1'b1;
        cyc();
        neg();
        check_val("rst_valid", 32'(bus.insn_valid), 32'd0);
        check_val("rst_pc", bus.pc_out, 32'd0);
        check_val("rst_insn", bus.insn_out, 32'd0);
        check_val("rst_en", 32'(bus.i_mem_enable), 32'd0);
        check_val("rst_addr", bus.address, BASE);
        check_val("rst_rw", 32'(bus.rw), 32'd1);
        check_val("rst_size", 32'(bus.access_size), 32'd0);

        // First fetch latency and steady stream
        cyc();
        reset = 1'b0;
        neg();
        check_val("first_en", 32'(bus.i_mem_enable), 32'd1);
        check_val("first_addr", bus.address, BASE);
        cyc(); neg();
        check_val("lat_valid0", 32'(bus.insn_valid), 32'd0);
        cyc(); neg();
        check_val("lat_valid1", 32'(bus.insn_valid), 32'd1);
        check_val("lat_pc0", bus.pc_out, BASE);
        cyc(); neg();
        check_val("lat_pc1", bus.pc_out, BASE + 32'd4);
        cyc(); neg();
        check_val("lat_pc2", bus.pc_out, BASE + 32'd8);

        // Stall from start fills queue with exactly DEPTH requests
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; bus.stall = 1'b1;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            neg();
            if (bus.i_mem_enable) reqs++;
            if (i == 9) begin
                check_val("full_en", 32'(bus.i_mem_enable), 32'd0);
                check_val("full_valid", 32'(bus.insn_valid), 32'd1);
                check_val("full_head", bus.pc_out, BASE);
            end
            cyc();
        end
        check_val("full_reqs", 32'(reqs), 32'(DEPTH));
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg();
            check_val("drain_valid", 32'(bus.insn_valid), 32'd1);
            check_val("drain_pc", bus.pc_out, BASE + 32'(4 * i));
            cyc();
        end

        // Branch with 3 queued and one in flight
        reset = 1'b1;
        cyc(); reset = 1'b0; bus.stall = 1'b1;
        repeat (4) cyc();
        bus.do_branch = 1'b1; bus.pc_effective = 32'h80020103;
        neg();
        check_val("br_pre_valid", 32'(bus.insn_valid), 32'd1);
        cyc(); bus.do_branch = 1'b0; bus.stall = 1'b0;
        neg();
        check_val("br_valid", 32'(bus.insn_valid), 32'd0);
        check_val("br_addr", bus.address, 32'h80020100);
        check_val("br_en", 32'(bus.i_mem_enable), 32'd1);
        cyc(); neg();
        check_val("br_valid1", 32'(bus.insn_valid), 32'd0);
        cyc(); neg();
        check_val("br_first_pc", bus.pc_out, 32'h80020100);

        // Address wrap at top of memory
        cyc(); bus.do_branch = 1'b1; bus.pc_effective = 32'hFFFFFFFC;
        cyc(); bus.do_branch = 1'b0;
        neg(); check_val("wrap_addr0", bus.address, 32'hFFFFFFFC);
        cyc(); neg(); check_val("wrap_addr1", bus.address, 32'h00000000);
        cyc(); neg(); check_val("wrap_pc0", bus.pc_out, 32'hFFFFFFFC);
        cyc(); neg(); check_val("wrap_pc1", bus.pc_out, 32'h00000000);

        // Reset mid-operation with a nearly full queue and a response in flight
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; bus.stall = 1'b1;
        repeat (4) cyc();
        reset = 1'b1;
        cyc(); reset = 1'b0; bus.stall = 1'b0;
        neg();
        check_val("mrst_valid", 32'(bus.insn_valid), 32'd0);
        check_val("mrst_addr", bus.address, BASE);
        check_val("mrst_pc", bus.pc_out, 32'd0);

`ifdef FETCH_PERF_CNT_EN
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; bus.stall = 1'b0;
        repeat (7) cyc();
        bus.stall = 1'b1;
        repeat (3) cyc();
        check_val("perf_stall", bus.stall_count, 32'd3);
        check_val("perf_fetch", bus.fetch_count, 32'(pushes_m));
        bus.stall = 1'b0;
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset         = ($urandom_range(0, 199) == 0);
            bus.stall     = ($urandom_range(0, 99) < 30);
            bus.do_branch = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0)
                bus.pc_effective = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else
                bus.pc_effective = $urandom;
        end
        cyc();
        neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
